// File: rtl/rect_fill_if.sv
// rect_fill_if -- request/pixel bus between a fill requester and rect_fill.
//   Request side : start, abort, x0/y0, x1/y1 (corner pair), colour_in
//   Pixel side   : x, y, colour, plot (write strobe), busy, done
// master = requester (drives request, watches pixel side)
// slave  = rect_fill (consumes request, drives pixel side)
interface rect_fill_if;
  logic       start;
  logic       abort;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, abort, x0, y0, x1, y1, colour_in,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, abort, x0, y0, x1, y1, colour_in,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_fill.sv
// rect_fill -- rasterises an axis-aligned filled rectangle into a pixel
// stream for a framebuffer adapter, one pixel per clock.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : rect_fill_if.slave
//     in  start, abort, x0/y0, x1/y1, colour_in
//     out x, y, colour, plot, busy, done (all registered)
// Corners may be given in any order; the far corner is clipped to the
// framebuffer. A rectangle whose near corner is off-screen is empty and
// completes with a done pulse and no plots.
module rect_fill #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clock,
  input  logic        reset,
  rect_fill_if.slave  bus
);

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  // rectangle bounds latched at accept; yl is not kept because y only
  // ever counts upward from its starting value
  logic [7:0] xl_q, xl_d;
  logic [7:0] xh_q, xh_d;
  logic [6:0] yh_q, yh_d;

  // ordered and clipped corners, only consumed on the accepting edge
  logic [7:0] cx_lo, cx_hi, cx_hi_clip;
  logic [6:0] cy_lo, cy_hi, cy_hi_clip;
  logic       empty;

  always_comb begin
    cx_lo      = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
    cx_hi      = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
    cy_lo      = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
    cy_hi      = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
    cx_hi_clip = (int'(cx_hi) > WIDTH - 1)  ? XMAX : cx_hi;
    cy_hi_clip = (int'(cy_hi) > HEIGHT - 1) ? YMAX : cy_hi;
    empty      = (int'(cx_lo) >= WIDTH) || (int'(cy_lo) >= HEIGHT);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    xl_d     = xl_q;
    xh_d     = xh_q;
    yh_d     = yh_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start beats abort here: abort is simply not looked at in IDLE
        if (bus.start) begin
          xl_d     = cx_lo;
          xh_d     = cx_hi_clip;
          yh_d     = cy_hi_clip;
          colour_d = bus.colour_in;
          busy_d   = 1'b1;
          if (empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
            x_d     = cx_lo;
            y_d     = cy_lo;
            plot_d  = 1'b1;
          end
        end
      end

      FILL: begin
        // the pixel at (x_q, y_q) is being plotted this cycle; decide
        // what follows it
        if (bus.abort) begin
          state_d = IDLE;
        end else if (x_q == xh_q && y_q == yh_q) begin
          state_d = DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          plot_d = 1'b1;
          if (x_q < xh_q) begin
            x_d = x_q + 8'd1;
          end else begin
            x_d = xl_q;
            y_d = y_q + 7'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      xl_q     <= '0;
      xh_q     <= '0;
      yh_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      xl_q     <= xl_d;
      xh_q     <= xh_d;
      yh_q     <= yh_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rect_fill.sv
module tb_rect_fill;

  localparam int W = 160;
  localparam int H = 120;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_ABORT = 2;
  localparam int EV_RESET = 3;

  logic clock;
  logic reset;
  rect_fill_if bus ();

  rect_fill #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  typedef struct {
    int    x0, y0, x1, y1, col;
    bit    ab_start;
    int    exp_n;
    int    exp_done;
    string nm;
  } vec_t;

  pix_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: the set of pixels a rectangle covers, listed in raster order.
  function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    if (xl < W && yl < H)
      for (int yy = yl; yy <= yh; yy++)
        for (int xx = xl; xx <= xh; xx++)
          exp_q.push_back(pix_t'{x: 8'(xx), y: 7'(yy)});
  endfunction

  // One fill: request at a negedge, accepted on the next posedge (cycle 0),
  // outputs sampled mid-cycle for cycles 1..last. exp_done < 0 means the
  // fill is killed by evt (abort/reset) at evt_cyc and no done may appear.
  task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int evt, input int evt_cyc, input bit ab_start,
                          input int exp_n, input int exp_done, input string nm);
    int    got, bad, done_cyc, extra_done, busy_err, last;
    string first;
    logic [7:0] lx;
    logic [6:0] ly;
    logic [2:0] lc;
    logic       lplot, ldone;
    model(ax0, ay0, ax1, ay1);
    got = 0; bad = 0; done_cyc = -1; extra_done = 0; busy_err = 0; first = "none";
    last = (exp_done >= 0) ? exp_done + 1 : evt_cyc + 1;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.abort     = ab_start;
    bus.x0        = 8'(ax0);
    bus.y0        = 7'(ay0);
    bus.x1        = 8'(ax1);
    bus.y1        = 7'(ay1);
    bus.colour_in = 3'(col);
    @(posedge clock);
    for (int c = 1; c <= last; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      reset     = 1'b0;
      bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
      bus.x1 = 8'($urandom); bus.y1 = 7'($urandom);
      bus.colour_in = 3'($urandom);
      if (bus.plot) begin
        if (!(got < exp_q.size() && c == got + 1 && bus.x == exp_q[got].x &&
              bus.y == exp_q[got].y && bus.colour == 3'(col))) begin
          if (bad == 0)
            first = $sformatf("cycle %0d at (%0d,%0d) colour %0d", c, bus.x, bus.y, bus.colour);
          bad++;
        end
        got++;
      end
      if (bus.done) begin
        if (done_cyc < 0) done_cyc = c;
        else extra_done++;
      end
      if (bus.busy !== (c < last)) busy_err++;
      lx = bus.x; ly = bus.y; lc = bus.colour; lplot = bus.plot; ldone = bus.done;
      if (c == evt_cyc) begin
        case (evt)
          EV_START: begin
            bus.start = 1'b1;
            bus.x0 = 8'd10; bus.y0 = 7'd10; bus.x1 = 8'd20; bus.y1 = 7'd20;
          end
          EV_ABORT: bus.abort = 1'b1;
          EV_RESET: reset = 1'b1;
          default: ;
        endcase
      end
    end
    chk({nm, " plot count"}, got, exp_n);
    chk({nm, " pixel order, first bad ", first}, bad, 0);
    chk({nm, " done cycle"}, done_cyc, exp_done);
    chk({nm, " extra done pulses"}, extra_done, 0);
    chk({nm, " busy profile errors"}, busy_err, 0);
    chk({nm, " final plot/done"}, {30'd0, lplot, ldone}, 0);
    if (evt == EV_RESET)
      chk({nm, " outputs zero after reset"}, {lx, ly, lc}, 0);
    else if (exp_done >= 0 && exp_q.size() > 0)
      chk({nm, " x/y/colour held in idle"}, {lx, ly, lc},
          {exp_q[exp_q.size()-1].x, exp_q[exp_q.size()-1].y, 3'(col)});
  endtask

  vec_t vecs[$];

  initial begin
    int idle_plot;
    int rx0, ry0, rx1, ry1, n;

    vecs.push_back('{5, 7, 5, 7, 5, 1'b0, 1, 2, "single pixel"});
    vecs.push_back('{3, 2, 1, 1, 6, 1'b0, 6, 7, "swapped corners"});
    vecs.push_back('{158, 118, 255, 127, 3, 1'b0, 4, 5, "clip corner"});
    vecs.push_back('{200, 0, 210, 5, 7, 1'b0, 0, 1, "off-screen x"});
    vecs.push_back('{4, 120, 9, 127, 2, 1'b0, 0, 1, "off-screen y"});
    vecs.push_back('{10, 20, 12, 20, 2, 1'b1, 3, 4, "start with abort"});
    vecs.push_back('{0, 119, 159, 119, 4, 1'b0, 160, 161, "bottom row"});
    vecs.push_back('{159, 0, 159, 119, 1, 1'b0, 120, 121, "right column"});

    bus.start = 1'b1; bus.abort = 1'b1;
    bus.x0 = 8'd1; bus.y0 = 7'd1; bus.x1 = 8'd2; bus.y1 = 7'd2; bus.colour_in = 3'd7;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset outputs (reset over start)",
        {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 0);
    bus.start = 1'b0; bus.abort = 1'b0; reset = 1'b0;
    @(negedge clock);
    chk("idle after reset", {bus.plot, bus.busy, bus.done}, 0);

    foreach (vecs[i])
      run_fill(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, EV_NONE, 0,
               vecs[i].ab_start, vecs[i].exp_n, vecs[i].exp_done, vecs[i].nm);

    run_fill(0, 0, 159, 119, 6, EV_START, 50, 1'b0, 19200, 19201, "full screen");

    run_fill(0, 0, 159, 119, 3, EV_ABORT, 10, 1'b0, 10, -1, "abort at 10");
    run_fill(2, 2, 3, 3, 5, EV_NONE, 0, 1'b0, 4, 5, "start after abort");

    run_fill(0, 0, 159, 119, 5, EV_RESET, 100, 1'b0, 100, -1, "reset at 100");
    idle_plot = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (bus.plot || bus.busy || bus.done) idle_plot++;
    end
    chk("quiet after reset", idle_plot, 0);
    run_fill(7, 3, 6, 4, 2, EV_NONE, 0, 1'b0, 4, 5, "start after reset");

    for (int t = 0; t < 25; t++) begin
      rx0 = $urandom_range(0, 255);
      ry0 = $urandom_range(0, 127);
      rx1 = rx0 + $urandom_range(0, 24) - 12;
      ry1 = ry0 + $urandom_range(0, 16) - 8;
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 255) rx1 = 255;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 127) ry1 = 127;
      model(rx0, ry0, rx1, ry1);
      n = exp_q.size();
      run_fill(rx0, ry0, rx1, ry1, int'($urandom_range(0, 7)), EV_NONE, 0, 1'($urandom),
               n, n + 1, $sformatf("random %0d (%0d,%0d)-(%0d,%0d)", t, rx0, ry0, rx1, ry1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
